// File: rtl/reg_writeback_queue.sv
// Register writeback queue: merges ALU and load writebacks into one in-order
// register-file write port, with two combinational forwarding lookups over
// the queued entries.
module reg_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_reg,
  input  logic [31:0]              alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_reg,
  input  logic [31:0]              ld_data,
  output logic                     RegWrite,
  output logic [4:0]               write_reg,
  output logic [31:0]              write_data,
  input  logic                     wr_ready,
  input  logic [4:0]               fwd_reg1,
  output logic                     fwd_hit1,
  output logic [31:0]              fwd_data1,
  input  logic [4:0]               fwd_reg2,
  output logic                     fwd_hit2,
  output logic [31:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    reg_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic [CW-1:0] free;
  logic          alu_push;
  logic          ld_push;
  logic          pop;
  logic [PW-1:0] ld_slot;

  // Handshake readiness from registered occupancy only; same-cycle pops do not free space
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    alu_ready = (free >= CW'(1));
    ld_ready  = (free >= CW'(2)) ||
                ((free == CW'(1)) && !(alu_valid && (alu_reg != 5'd0)));
    alu_push  = alu_valid && alu_ready && (alu_reg != 5'd0);
    ld_push   = ld_valid  && ld_ready  && (ld_reg  != 5'd0);
    pop       = RegWrite && wr_ready;
    // Load lands behind the ALU entry when both enqueue together
    ld_slot   = wr_ptr_q + PW'(alu_push);
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(alu_push) + PW'(ld_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(alu_push) + CW'(ld_push) - CW'(pop);
  end

  // Queue storage and pointers; reset discards every entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (alu_push) begin
        reg_q[wr_ptr_q]  <= alu_reg;
        data_q[wr_ptr_q] <= alu_data;
      end
      if (ld_push) begin
        reg_q[ld_slot]  <= ld_reg;
        data_q[ld_slot] <= ld_data;
      end
    end
  end

  // Register-file write port driven by the head entry, zeroed when empty
  always_comb begin
    RegWrite   = (count_q != '0);
    write_reg  = RegWrite ? reg_q[rd_ptr_q]  : '0;
    write_data = RegWrite ? data_q[rd_ptr_q] : '0;
  end

  // Forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (i < 32'(count_q)) begin
        if ((fwd_reg1 != 5'd0) && (reg_q[idx] == fwd_reg1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if ((fwd_reg2 != 5'd0) && (reg_q[idx] == fwd_reg2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: a queue-based reference model checked every
// falling edge, plus hand-computed expectations for the directed scenarios.
module tb_reg_writeback_queue;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_reg;
  logic [31:0] ld_data;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        wr_ready;
  logic [4:0]  fwd_reg1, fwd_reg2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .wr_ready(wr_ready),
    .fwd_reg1(fwd_reg1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_reg2(fwd_reg2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes, oldest at the front
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  function automatic logic m_alu_ready();
    return (DEPTH - q.size()) >= 1;
  endfunction

  function automatic logic m_ld_ready();
    int unsigned fr;
    fr = DEPTH - q.size();
    return (fr >= 2) || (fr == 1 && !(alu_valid && alu_reg != 5'd0));
  endfunction

  task automatic m_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 5'd0)
      foreach (q[i])
        if (q[i].r == r) begin
          hit = 1'b1;
          d   = q[i].d;
        end
  endtask

  always @(negedge reset_n) q.delete();

  always @(posedge clock) begin
    logic ar, lr;
    if (reset_n) begin
      ar = m_alu_ready();
      lr = m_ld_ready();
      if (q.size() != 0 && wr_ready) void'(q.pop_front());
      if (alu_valid && ar && alu_reg != 5'd0) q.push_back('{r: alu_reg, d: alu_data});
      if (ld_valid && lr && ld_reg != 5'd0) q.push_back('{r: ld_reg, d: ld_data});
    end
  end

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clock) begin
    logic        h;
    logic [31:0] d;
    chk("m_count", 32'(count), q.size());
    chk("m_regwrite", 32'(RegWrite), 32'(q.size() != 0));
    chk("m_write_reg", 32'(write_reg), q.size() != 0 ? 32'(q[0].r) : 32'd0);
    chk("m_write_data", write_data, q.size() != 0 ? q[0].d : 32'd0);
    chk("m_alu_ready", 32'(alu_ready), 32'(m_alu_ready()));
    chk("m_ld_ready", 32'(ld_ready), 32'(m_ld_ready()));
    m_fwd(fwd_reg1, h, d);
    chk("m_fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("m_fwd_data1", fwd_data1, d);
    m_fwd(fwd_reg2, h, d);
    chk("m_fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("m_fwd_data2", fwd_data2, d);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = '0; alu_data = '0;
    ld_valid  = 0; ld_reg  = '0; ld_data  = '0;
  endtask

  initial begin
    reset_n = 1'b1;
    idle_inputs();
    wr_ready = 0; fwd_reg1 = '0; fwd_reg2 = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    tick(); tick();
    @(negedge clock); #1 reset_n = 1'b1;

    // Single ALU push retires one cycle later
    tick();
    alu_valid = 1; alu_reg = 5'd5; alu_data = 32'h1234; wr_ready = 1;
    tick();
    idle_inputs();
    #1;
    chk("p030_regwrite", 32'(RegWrite), 1);
    chk("p030_write_reg", 32'(write_reg), 5);
    chk("p030_write_data", write_data, 32'h1234);
    tick();
    chk("p030_count_after", 32'(count), 0);
    chk("p030_regwrite_after", 32'(RegWrite), 0);

    // Dual push to same register: youngest forwards, oldest retires first
    wr_ready = 0; fwd_reg1 = 5'd3;
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'hA;
    ld_valid  = 1; ld_reg  = 5'd3; ld_data  = 32'hB;
    tick();
    idle_inputs();
    #1;
    chk("p031_count", 32'(count), 2);
    chk("p031_fwd_hit", 32'(fwd_hit1), 1);
    chk("p031_fwd_data", fwd_data1, 32'hB);
    chk("p031_head_first", write_data, 32'hA);
    wr_ready = 1;
    tick();
    chk("p031_head_second", write_data, 32'hB);
    tick();
    chk("p031_drained", 32'(count), 0);
    wr_ready = 0; fwd_reg1 = '0;

    // Register-zero push is accepted but dropped
    alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hDEAD; fwd_reg2 = 5'd0;
    #1 chk("p032_alu_ready", 32'(alu_ready), 1);
    tick();
    idle_inputs();
    #1;
    chk("p032_count", 32'(count), 0);
    chk("p032_regwrite", 32'(RegWrite), 0);
    chk("p032_fwd_hit", 32'(fwd_hit2), 0);
    chk("p032_fwd_data", fwd_data2, 0);

    // Fill to 3, then both valid with one free slot: ALU wins, load stalls
    alu_valid = 1; alu_reg = 5'd1; alu_data = 32'h11;
    ld_valid  = 1; ld_reg  = 5'd2; ld_data  = 32'h22;
    tick();
    idle_inputs();
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h33;
    tick();
    alu_valid = 1; alu_reg = 5'd4; alu_data = 32'h44;
    ld_valid  = 1; ld_reg  = 5'd5; ld_data  = 32'h55;
    #1;
    chk("p034_count3", 32'(count), 3);
    chk("p034_alu_ready", 32'(alu_ready), 1);
    chk("p034_ld_ready", 32'(ld_ready), 0);
    tick();
    #1;
    chk("p033_count_full", 32'(count), 4);
    chk("p033_alu_ready", 32'(alu_ready), 0);
    chk("p033_ld_ready", 32'(ld_ready), 0);
    idle_inputs();
    fwd_reg1 = 5'd4; fwd_reg2 = 5'd5;
    #1;
    chk("p034_fwd_alu", fwd_data1, 32'h44);
    chk("p034_fwd_ld_stalled", 32'(fwd_hit2), 0);

    // Drain in order across the pointer wrap, then a fifth push
    wr_ready = 1;
    chk("p035_head0", write_data, 32'h11);
    tick(); chk("p035_head1", write_data, 32'h22);
    tick(); chk("p035_head2", write_data, 32'h33);
    tick(); chk("p035_head3", write_data, 32'h44);
    tick(); chk("p035_empty", 32'(count), 0);
    alu_valid = 1; alu_reg = 5'd6; alu_data = 32'h66;
    tick();
    idle_inputs();
    #1;
    chk("p035_fifth_reg", 32'(write_reg), 6);
    chk("p035_fifth_data", write_data, 32'h66);
    tick();
    chk("p035_fifth_retired", 32'(count), 0);

    // Half-cycle reset pulse with three entries queued
    wr_ready = 0; fwd_reg1 = 5'd7; fwd_reg2 = '0;
    alu_valid = 1; alu_reg = 5'd7; alu_data = 32'h70;
    ld_valid  = 1; ld_reg  = 5'd8; ld_data  = 32'h80;
    tick();
    idle_inputs();
    alu_valid = 1; alu_reg = 5'd9; alu_data = 32'h90;
    tick();
    idle_inputs();
    chk("p036_count_before", 32'(count), 3);
    reset_n = 1'b0;
    #1;
    chk("p036_count", 32'(count), 0);
    chk("p036_regwrite", 32'(RegWrite), 0);
    chk("p036_write_data", write_data, 0);
    chk("p036_fwd_hit", 32'(fwd_hit1), 0);
    chk("p036_alu_ready", 32'(alu_ready), 1);
    @(negedge clock); #1 reset_n = 1'b1;
    wr_ready = 1;
    tick();
    chk("p036_no_write", 32'(RegWrite), 0);

    // First push after reset release is accepted
    alu_valid = 1; alu_reg = 5'd10; alu_data = 32'hAA;
    tick();
    idle_inputs();
    #1;
    chk("p029_first_push", 32'(count), 1);
    chk("p029_first_data", write_data, 32'hAA);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
